// File: rtl/multi_tone_generator.sv
// multi_tone_generator: CHANNELS independent square-wave tone channels, each
// dividing clk by a runtime-programmable half-period, plus a PWM mixer that
// folds all channels onto one buzzer pin.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   wr_en      write strobe (one channel per cycle)
//   wr_ch      channel index to write; indices >= CHANNELS are ignored
//   wr_half    half-period H for the selected channel
//   wr_enable  channel enable written together with H
//   sound      per-channel square wave, bit i = channel i
//   mix_level  registered count of channels whose sound bit is high
//   sound_mix  PWM-mixed buzzer output, duty = mix_level / CHANNELS
module multi_tone_generator #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 22,
  parameter int unsigned CH_W     = $clog2(CHANNELS),
  parameter int unsigned LVL_W    = $clog2(CHANNELS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [CNT_W-1:0]    wr_half,
  input  logic                wr_enable,
  output logic [CHANNELS-1:0] sound,
  output logic [LVL_W-1:0]    mix_level,
  output logic                sound_mix
);

  logic [CHANNELS-1:0] sound_vec;

  // Per-channel half-period divider. A write wins over a toggle due on the
  // same edge and restarts the counter at 0, so num_q can never overshoot
  // the new half_q and wrap.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CNT_W-1:0] half_q;
    logic [CNT_W-1:0] num_q;
    logic             en_q;
    logic             sound_q;
    logic             wr_hit;

    // Only indices 0..CHANNELS-1 can match, so out-of-range writes drop out.
    assign wr_hit = wr_en && (wr_ch == CH_W'(i));

    always_ff @(posedge clk) begin
      if (rst) begin
        half_q  <= '0;
        num_q   <= '0;
        en_q    <= 1'b0;
        sound_q <= 1'b0;
      end else if (wr_hit) begin
        half_q <= wr_half;
        en_q   <= wr_enable;
        num_q  <= '0;
        if (!wr_enable) begin
          sound_q <= 1'b0;
        end
      end else if (!en_q) begin
        num_q   <= '0;
        sound_q <= 1'b0;
      end else if (num_q == half_q) begin
        sound_q <= ~sound_q;
        num_q   <= '0;
      end else begin
        num_q <= num_q + CNT_W'(1);
      end
    end

    assign sound_vec[i] = sound_q;
  end

  // Number of channels currently high.
  logic [LVL_W-1:0] level_c;

  always_comb begin
    level_c = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      level_c = level_c + LVL_W'(sound_vec[k]);
    end
  end

  // PWM mixer: a CHANNELS-cycle frame with level_q high slots.
  logic [CH_W-1:0]  pwm_cnt;
  logic [LVL_W-1:0] level_q;
  logic             mix_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      level_q <= '0;
      mix_q   <= 1'b0;
    end else begin
      level_q <= level_c;
      mix_q   <= (LVL_W'(pwm_cnt) < level_q);
      if (pwm_cnt == CH_W'(CHANNELS - 1)) begin
        pwm_cnt <= '0;
      end else begin
        pwm_cnt <= pwm_cnt + CH_W'(1);
      end
    end
  end

  assign sound     = sound_vec;
  assign mix_level = level_q;
  assign sound_mix = mix_q;

endmodule

// File: tb/tb_multi_tone_generator.sv
// Directed bench for multi_tone_generator. Instance "dut" is the default
// 4-channel build; instance "dut_b" is a 3-channel, 8-bit-counter build used
// for the maximum half-period case and for an out-of-range channel index.
module tb_multi_tone_generator;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [21:0] wr_half;
  logic        wr_enable;
  logic [3:0]  sound;
  logic [2:0]  mix_level;
  logic        sound_mix;

  logic        b_wr_en;
  logic [1:0]  b_wr_ch;
  logic [7:0]  b_wr_half;
  logic        b_wr_enable;
  logic [2:0]  b_sound;
  logic [1:0]  b_mix_level;
  logic        b_sound_mix;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multi_tone_generator dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_half   (wr_half),
    .wr_enable (wr_enable),
    .sound     (sound),
    .mix_level (mix_level),
    .sound_mix (sound_mix)
  );

  multi_tone_generator #(.CHANNELS(3), .CNT_W(8)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (b_wr_en),
    .wr_ch     (b_wr_ch),
    .wr_half   (b_wr_half),
    .wr_enable (b_wr_enable),
    .sound     (b_sound),
    .mix_level (b_mix_level),
    .sound_mix (b_sound_mix)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // All tasks start and end just after a falling edge; outputs are sampled there.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int ch, input int half, input bit en);
    wr_en     = 1'b1;
    wr_ch     = 2'(ch);
    wr_half   = 22'(half);
    wr_enable = en;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wrb(input int ch, input int half, input bit en);
    b_wr_en     = 1'b1;
    b_wr_ch     = 2'(ch);
    b_wr_half   = 8'(half);
    b_wr_enable = en;
    @(negedge clk);
    b_wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Count sound_mix highs over n consecutive cycles.
  task automatic count_mix(input int n, output int highs);
    highs = 0;
    repeat (n) begin
      if (sound_mix) highs++;
      step(1);
    end
  endtask

  int highs;

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_half = '0; wr_enable = 1'b0;
    b_wr_en = 1'b0; b_wr_ch = '0; b_wr_half = '0; b_wr_enable = 1'b0;
    step(2);
    rst = 1'b0;

    // Reset after random activity, including a write on the reset edge.
    for (int c = 0; c < 4; c++) wr(c, int'($urandom_range(0, 3)), 1'b1);
    step(10);
    wr_en = 1'b1; wr_ch = 2'd0; wr_half = 22'd0; wr_enable = 1'b1;
    do_reset();
    wr_en = 1'b0;
    check("rst_sound", 32'(sound), 32'h0);
    check("rst_level", 32'(mix_level), 32'h0);
    check("rst_mix", 32'(sound_mix), 32'h0);
    step(20);
    check("rst_silent", 32'(sound), 32'h0);

    // Channel 0, H=3: rise at E0+4, fall at E0+8, period 8.
    wr(0, 3, 1'b1);
    check("h3_e0", 32'(sound), 32'h0);
    step(3);
    check("h3_e3", 32'(sound), 32'h0);
    step(1);
    check("h3_e4", 32'(sound), 32'h1);
    step(3);
    check("h3_e7", 32'(sound), 32'h1);
    step(1);
    check("h3_e8", 32'(sound), 32'h0);
    step(4);
    check("h3_e12", 32'(sound), 32'h1);
    step(4);
    check("h3_e16", 32'(sound), 32'h0);

    // Channel 1, H=0: toggles every clock.
    do_reset();
    wr(1, 0, 1'b1);
    check("h0_e0", 32'(sound), 32'h0);
    step(1);
    check("h0_e1", 32'(sound), 32'h2);
    step(1);
    check("h0_e2", 32'(sound), 32'h0);
    step(1);
    check("h0_e3", 32'(sound), 32'h2);

    // Small build: H = 2^8-1 rises at E0+256; an index-3 write mid-count is ignored.
    do_reset();
    wrb(2, 255, 1'b1);
    step(99);
    wrb(3, 0, 1'b1);
    check("oor_after", 32'(b_sound), 32'h0);
    step(155);
    check("hmax_e255", 32'(b_sound), 32'h0);
    step(1);
    check("hmax_e256", 32'(b_sound), 32'h4);

    // Rewrite H=10 -> H=2 when num_q=7: no toggle on write, toggle 3 later, period 6.
    do_reset();
    wr(0, 10, 1'b1);
    step(7);
    wr(0, 2, 1'b1);
    check("rw_w0", 32'(sound), 32'h0);
    step(2);
    check("rw_w2", 32'(sound), 32'h0);
    step(1);
    check("rw_w3", 32'(sound), 32'h1);
    step(2);
    check("rw_w5", 32'(sound), 32'h1);
    step(1);
    check("rw_w6", 32'(sound), 32'h0);
    step(3);
    check("rw_w9", 32'(sound), 32'h1);
    // Enabled rewrite on a due fall keeps sound high and restarts the count.
    step(2);
    wr(0, 2, 1'b1);
    check("rw_w12_hold", 32'(sound), 32'h1);
    step(2);
    check("rw_w14", 32'(sound), 32'h1);
    step(1);
    check("rw_w15", 32'(sound), 32'h0);

    // Disable on the edge a rise is due, then re-enable.
    do_reset();
    wr(0, 5, 1'b1);
    step(5);
    check("dis_e5", 32'(sound), 32'h0);
    wr(0, 5, 1'b0);
    check("dis_e6", 32'(sound), 32'h0);
    step(20);
    check("dis_held", 32'(sound), 32'h0);
    wr(0, 5, 1'b1);
    step(5);
    check("reen_r5", 32'(sound), 32'h0);
    step(1);
    check("reen_r6", 32'(sound), 32'h1);

    // Mixer: all four channels H=999 on consecutive cycles, all high by E0+1003.
    do_reset();
    for (int c = 0; c < 4; c++) wr(c, 999, 1'b1);
    step(1497);
    check("mix4_sound", 32'(sound), 32'hF);
    check("mix4_level", 32'(mix_level), 32'h4);
    count_mix(8, highs);
    check("mix4_duty", 32'(highs), 32'd8);

    wr(2, 999, 1'b0);
    wr(3, 999, 1'b0);
    step(4);
    check("mix2_level", 32'(mix_level), 32'h2);
    count_mix(8, highs);
    check("mix2_duty", 32'(highs), 32'd4);

    wr(0, 999, 1'b0);
    step(4);
    check("mix1_level", 32'(mix_level), 32'h1);
    count_mix(8, highs);
    check("mix1_duty", 32'(highs), 32'd2);

    wr(1, 999, 1'b0);
    step(4);
    check("mix0_level", 32'(mix_level), 32'h0);
    count_mix(8, highs);
    check("mix0_duty", 32'(highs), 32'd0);

    // Mid-operation reset with a nonzero level.
    wr(0, 0, 1'b1);
    wr(1, 0, 1'b1);
    step(6);
    do_reset();
    check("rst2_sound", 32'(sound), 32'h0);
    check("rst2_level", 32'(mix_level), 32'h0);
    check("rst2_mix", 32'(sound_mix), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
